// File: rtl/window_gen9x9_pkg.sv
// Shared constants for the 9x9 window generator and the downstream inner-product stage.
// idx(r,c) maps a window row/column to its flat element index.
package window_gen9x9_pkg;
  localparam int PIX_W = 7;
  localparam int K     = 9;
  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int NPIX  = K * K;
  localparam int WIN_W = NPIX * PIX_W;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  function automatic int idx(input int r, input int c);
    return r * K + c;
  endfunction
endpackage

// File: rtl/window_gen9x9_line_row_buf.sv
// One frame row of pixel delay: the old value at addr_i is read combinationally
// in the same cycle the new pixel is written there (read-before-write).
module line_row_buf
  import window_gen9x9_pkg::*;
(
  input  logic             clk,
  input  logic             we_i,
  input  logic [COL_W-1:0] addr_i,
  input  logic [PIX_W-1:0] din_i,
  output logic [PIX_W-1:0] dout_o
);

  logic [PIX_W-1:0] mem_q [IMG_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= din_i;
  end

  assign dout_o = mem_q[addr_i];

endmodule

// File: rtl/window_gen9x9.sv
// Raster-order pixel stream in, every fully-inside 9x9 window out as a flat bus.
// The window shift register doubles as the single-entry output slot.
module window_gen9x9
  import window_gen9x9_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pix,
  output logic             in_ready,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [WIN_W-1:0] win_data,
  output logic             win_last
);

  logic [COL_W-1:0] col_q, col_d, col_eff;
  logic [ROW_W-1:0] row_q, row_d, row_eff;
  logic [WIN_W-1:0] win_q, win_d;
  logic             win_valid_q, win_valid_d;
  logic             win_last_q, win_last_d;
  logic             accept;
  logic [PIX_W-1:0] tap      [K-1];
  logic [PIX_W-1:0] chain_in [K-1];

  // Accepting only when the slot is free or being drained keeps win_q stable while stalled.
  assign in_ready = !rst && (!win_valid_q || win_ready);
  assign accept   = in_valid && in_ready;
  assign col_eff  = in_sof ? '0 : col_q;
  assign row_eff  = in_sof ? '0 : row_q;

  // tap[j] holds the pixel j+1 rows above the incoming one, same column.
  for (genvar j = 0; j < K - 1; j++) begin : g_line
    if (j == 0) begin : g_head
      assign chain_in[j] = in_pix;
    end else begin : g_tail
      assign chain_in[j] = tap[j-1];
    end
    line_row_buf u_buf (
      .clk    (clk),
      .we_i   (accept),
      .addr_i (col_eff),
      .din_i  (chain_in[j]),
      .dout_o (tap[j])
    );
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    if (win_valid_q && win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[idx(r, c)*PIX_W +: PIX_W] = win_q[idx(r, c + 1)*PIX_W +: PIX_W];
        end
      end
      for (int r = 0; r < K - 1; r++) begin
        win_d[idx(r, K - 1)*PIX_W +: PIX_W] = tap[K-2-r];
      end
      win_d[idx(K - 1, K - 1)*PIX_W +: PIX_W] = in_pix;
      win_valid_d = (row_eff >= ROW_W'(K - 1)) && (col_eff >= COL_W'(K - 1));
      win_last_d  = (row_eff == ROW_W'(IMG_H - 1)) && (col_eff == COL_W'(IMG_W - 1));
      if (col_eff == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_eff == ROW_W'(IMG_H - 1)) ? '0 : row_eff + ROW_W'(1);
      end else begin
        col_d = col_eff + COL_W'(1);
        row_d = row_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_data  = win_q;
  assign win_last  = win_last_q;

endmodule

// File: tb/tb_window_gen9x9.sv
// Randomized bench for window_gen9x9 against a frame-array reference model
// that builds each expected window directly from stored pixel positions.
module tb_window_gen9x9;
  import window_gen9x9_pkg::*;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_sof, win_ready;
  logic [PIX_W-1:0] in_pix;
  logic             in_ready, win_valid, win_last;
  logic [WIN_W-1:0] win_data;

  always #5 clk = ~clk;

  window_gen9x9 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_pix    (in_pix),
    .in_ready  (in_ready),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_last  (win_last)
  );

  int               checks = 0;
  int               errors = 0;
  int               fr [IMG_H][IMG_W];
  int               mr, mc;
  logic [WIN_W-1:0] exp_q [$];
  bit               expl_q [$];
  bit               hold_active;
  logic [WIN_W-1:0] held, first_win, last_win, cap_win;
  int               win_cnt, last_cnt, cap_idx;
  bit               ramp;

  task automatic chk(input string tag, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [PIX_W-1:0] elem(input logic [WIN_W-1:0] w, input int i);
    return w[i*PIX_W +: PIX_W];
  endfunction

  task automatic model_accept(input logic [PIX_W-1:0] p, input bit s);
    logic [WIN_W-1:0] w;
    if (s) begin
      mr = 0;
      mc = 0;
    end
    fr[mr][mc] = int'(p);
    if (mr >= K - 1 && mc >= K - 1) begin
      w = '0;
      for (int i = 0; i < NPIX; i++)
        w[i*PIX_W +: PIX_W] = PIX_W'(fr[mr-K+1+i/K][mc-K+1+i%K]);
      exp_q.push_back(w);
      expl_q.push_back(mr == IMG_H - 1 && mc == IMG_W - 1);
    end
    mc++;
    if (mc == IMG_W) begin
      mc = 0;
      mr++;
      if (mr == IMG_H) mr = 0;
    end
  endtask

  task automatic cycle(input bit v, input bit s, input logic [PIX_W-1:0] p,
                       input bit wr, input bit r_in, output bit acc);
    logic [WIN_W-1:0] d;
    bit               l;
    bit               full;
    @(posedge clk);
    #1;
    rst       = r_in;
    in_valid  = v;
    in_sof    = s;
    in_pix    = p;
    win_ready = wr;
    @(negedge clk);
    full = (exp_q.size() != 0);
    acc  = v && !r_in && (!full || wr);
    chk("in_ready", WIN_W'(in_ready), WIN_W'(!r_in && (!full || wr)));
    chk("win_valid", WIN_W'(win_valid), WIN_W'(full));
    if (hold_active) chk("hold_data", win_data, held);
    hold_active = 1'b0;
    if (full && wr && !r_in) begin
      d = exp_q.pop_front();
      l = expl_q.pop_front();
      chk("win_data", win_data, d);
      chk("win_last", WIN_W'(win_last), WIN_W'(l));
      if (win_cnt == 0) first_win = win_data;
      if (win_cnt == cap_idx) cap_win = win_data;
      if (win_last) begin
        last_win = win_data;
        last_cnt++;
      end
      win_cnt++;
    end else if (full) begin
      hold_active = 1'b1;
      held        = win_data;
    end
    if (acc) model_accept(p, s);
  endtask

  task automatic send_pixels(input int n, input bit sof_first, input bit rand_ready, input bit rand_valid);
    int               sent = 0;
    int               guard = 0;
    bit               v, s, wr, acc;
    int               pr, pc;
    logic [PIX_W-1:0] p;
    while (sent < n && guard < 20 * n + 100) begin
      v  = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      s  = sof_first && (sent == 0);
      pr = s ? 0 : mr;
      pc = s ? 0 : mc;
      p  = ramp ? PIX_W'((pr * IMG_W + pc) % 128) : PIX_W'($urandom);
      wr = rand_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
      cycle(v, s, p, wr, 1'b0, acc);
      if (acc) sent++;
      guard++;
    end
    chk("send_timeout", WIN_W'(sent), WIN_W'(n));
  endtask

  task automatic drain();
    bit acc;
    int guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, acc);
      guard++;
    end
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, acc);
    chk("drain", WIN_W'(exp_q.size()), WIN_W'(0));
  endtask

  task automatic reset_dut();
    bit acc;
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, acc);
    exp_q.delete();
    expl_q.delete();
    hold_active = 1'b0;
    mr = 0;
    mc = 0;
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, acc);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, acc);
    chk("rst_data", win_data, '0);
    chk("rst_last", WIN_W'(win_last), WIN_W'(0));
  endtask

  task automatic start_count(input int cap);
    win_cnt  = 0;
    last_cnt = 0;
    cap_idx  = cap;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pix = '0; win_ready = 1'b0;
    mr = 0; mc = 0; hold_active = 1'b0; cap_idx = -1; win_cnt = 0; last_cnt = 0;
    first_win = '0; last_win = '0; cap_win = '0; held = '0;
    reset_dut();

    // ramp frame, no stalls
    ramp = 1'b1;
    start_count(-1);
    send_pixels(IMG_W * IMG_H, 1'b1, 1'b0, 1'b0);
    drain();
    chk("ramp_count", WIN_W'(win_cnt), WIN_W'(400));
    chk("ramp_lastcnt", WIN_W'(last_cnt), WIN_W'(1));
    chk("ramp_e0", WIN_W'(elem(first_win, 0)), WIN_W'(0));
    chk("ramp_e8", WIN_W'(elem(first_win, 8)), WIN_W'(8));
    chk("ramp_e72", WIN_W'(elem(first_win, 72)), WIN_W'(96));
    chk("ramp_e80", WIN_W'(elem(first_win, 80)), WIN_W'(104));
    chk("ramp_last_e80", WIN_W'(elem(last_win, 80)), WIN_W'(15));

    // ramp with consumer and producer stalls
    start_count(-1);
    send_pixels(IMG_W * IMG_H, 1'b1, 1'b1, 1'b1);
    drain();
    chk("stall_count", WIN_W'(win_cnt), WIN_W'(400));
    chk("stall_last_e80", WIN_W'(elem(last_win, 80)), WIN_W'(15));

    // random pixels with stalls
    ramp = 1'b0;
    start_count(-1);
    send_pixels(IMG_W * IMG_H, 1'b1, 1'b1, 1'b1);
    drain();
    chk("rand_count", WIN_W'(win_cnt), WIN_W'(400));

    // sof at (15,3) aborts the partial frame
    send_pixels(15 * IMG_W + 3, 1'b1, 1'b1, 1'b1);
    start_count(-1);
    send_pixels(IMG_W * IMG_H, 1'b1, 1'b1, 1'b1);
    drain();
    chk("sof_count", WIN_W'(win_cnt), WIN_W'(400));
    chk("sof_lastcnt", WIN_W'(last_cnt), WIN_W'(1));

    // reset right after accepting (20,20), then a frame without sof
    ramp = 1'b1;
    send_pixels(20 * IMG_W + 21, 1'b1, 1'b0, 1'b0);
    chk("pend_before_rst", WIN_W'(exp_q.size()), WIN_W'(1));
    reset_dut();
    start_count(-1);
    send_pixels(IMG_W * IMG_H, 1'b0, 1'b0, 1'b0);
    drain();
    chk("postrst_count", WIN_W'(win_cnt), WIN_W'(400));
    chk("postrst_e0", WIN_W'(elem(first_win, 0)), WIN_W'(0));
    chk("postrst_last_e80", WIN_W'(elem(last_win, 80)), WIN_W'(15));

    // two back-to-back frames
    start_count(400);
    send_pixels(2 * IMG_W * IMG_H, 1'b1, 1'b0, 1'b0);
    drain();
    chk("b2b_count", WIN_W'(win_cnt), WIN_W'(800));
    chk("b2b_lastcnt", WIN_W'(last_cnt), WIN_W'(2));
    chk("b2b_f2_e0", WIN_W'(elem(cap_win, 0)), WIN_W'(0));
    chk("b2b_f2_e80", WIN_W'(elem(cap_win, 80)), WIN_W'(104));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
